// File: rtl/dsp_cpl_sync.sv
`timescale 1ns/1ps
// dsp_cpl_sync: hands a DSP completion {op, waddr} from clk_dsp to the CPU on clk
// with a req/ack toggle handshake. The payload register is held stable while a
// completion is pending, so the CPU reads it directly without resampling.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   C_IDLE | no launch outstanding, no completion presented
//   C_WAIT | launch outstanding, timeout counter running (o_busy)
//   C_CPL  | completion presented on o_cpl_valid until i_cpl_ready
//   D_IDLE | DSP side free, next i_dsp_done is captured
//   D_PEND | DSP side holding payload until the CPU ack toggle returns
module dsp_cpl_sync #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_dsp,
  input  logic       i_start,
  input  logic       i_dsp_done,
  input  logic [1:0] i_dsp_waddr,
  input  logic [1:0] i_dsp_op,
  output logic       o_cpl_valid,
  input  logic       i_cpl_ready,
  output logic [3:0] o_cpl_data,
  output logic       o_cpl_unsol,
  output logic       o_busy,
  output logic       o_start_err,
  output logic       o_timeout,
  output logic       o_dsp_overrun
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {C_IDLE = 2'd0, C_WAIT = 2'd1, C_CPL = 2'd2} cpu_state_t;
  typedef enum logic {D_IDLE = 1'b0, D_PEND = 1'b1} dsp_state_t;

  logic [1:0] rst_cpu_q, rst_dsp_q;
  logic       rst_cpu, rst_dsp;

  cpu_state_t state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic        unsol_q, unsol_nxt;
  logic        ack_tgl, ack_nxt;
  logic        start_err_q, start_err_nxt;
  logic        timeout_q, timeout_nxt;
  logic        req_s1, req_s2, req_d, req_edge;

  dsp_state_t d_state, d_state_nxt;
  logic [3:0] payload, payload_nxt;
  logic       req_tgl, req_nxt;
  logic       ovr_q, ovr_nxt;
  logic       ack_s1, ack_s2, ack_d, ack_edge;

  // Reset synchronizer, clk domain: asserts at once, releases on clk edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rst_cpu_q <= 2'b11;
    else       rst_cpu_q <= {rst_cpu_q[0], 1'b0};
  end

  // Reset synchronizer, clk_dsp domain.
  always_ff @(posedge clk_dsp or posedge reset) begin
    if (reset) rst_dsp_q <= 2'b11;
    else       rst_dsp_q <= {rst_dsp_q[0], 1'b0};
  end

  assign rst_cpu  = rst_cpu_q[1];
  assign rst_dsp  = rst_dsp_q[1];
  assign req_edge = req_s2 ^ req_d;
  assign ack_edge = ack_s2 ^ ack_d;

  // req toggle into clk: two sync flops plus the edge-detect register.
  always_ff @(posedge clk or posedge rst_cpu) begin
    if (rst_cpu) begin
      req_s1 <= 1'b0;
      req_s2 <= 1'b0;
      req_d  <= 1'b0;
    end else begin
      req_s1 <= req_tgl;
      req_s2 <= req_s1;
      req_d  <= req_s2;
    end
  end

  // CPU FSM state register plus the registered pulses and ack toggle.
  always_ff @(posedge clk or posedge rst_cpu) begin
    if (rst_cpu) begin
      state       <= C_IDLE;
      cnt         <= 16'd0;
      unsol_q     <= 1'b0;
      ack_tgl     <= 1'b0;
      start_err_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      unsol_q     <= unsol_nxt;
      ack_tgl     <= ack_nxt;
      start_err_q <= start_err_nxt;
      timeout_q   <= timeout_nxt;
    end
  end

  // CPU FSM next state; a completion edge always beats the timeout.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    unsol_nxt     = unsol_q;
    ack_nxt       = ack_tgl;
    start_err_nxt = 1'b0;
    timeout_nxt   = 1'b0;
    case (state)
      C_IDLE: begin
        if (req_edge) begin
          // The completion takes the slot, so a coincident launch is rejected.
          state_nxt     = C_CPL;
          unsol_nxt     = 1'b1;
          start_err_nxt = i_start;
        end else if (i_start) begin
          state_nxt = C_WAIT;
          cnt_nxt   = 16'd0;
        end
      end
      C_WAIT: begin
        if (cnt != 16'hFFFF) cnt_nxt = cnt + 16'd1;
        start_err_nxt = i_start;
        if (req_edge) begin
          state_nxt = C_CPL;
          unsol_nxt = 1'b0;
        end else if (cnt == TO_LAST) begin
          state_nxt   = C_IDLE;
          timeout_nxt = 1'b1;
        end
      end
      C_CPL: begin
        if (i_cpl_ready) begin
          ack_nxt   = ~ack_tgl;
          unsol_nxt = 1'b0;
          if (i_start) begin
            state_nxt = C_WAIT;
            cnt_nxt   = 16'd0;
          end else begin
            state_nxt = C_IDLE;
          end
        end else begin
          start_err_nxt = i_start;
        end
      end
      default: state_nxt = C_IDLE;
    endcase
  end

  // CPU-side outputs decoded from state.
  always_comb begin
    o_busy      = (state == C_WAIT);
    o_cpl_valid = (state == C_CPL);
    o_cpl_unsol = (state == C_CPL) & unsol_q;
  end

  assign o_start_err = start_err_q;
  assign o_timeout   = timeout_q;

  // ack toggle into clk_dsp: two sync flops plus the edge-detect register.
  always_ff @(posedge clk_dsp or posedge rst_dsp) begin
    if (rst_dsp) begin
      ack_s1 <= 1'b0;
      ack_s2 <= 1'b0;
      ack_d  <= 1'b0;
    end else begin
      ack_s1 <= ack_tgl;
      ack_s2 <= ack_s1;
      ack_d  <= ack_s2;
    end
  end

  // DSP FSM state register with payload, req toggle and sticky overrun.
  always_ff @(posedge clk_dsp or posedge rst_dsp) begin
    if (rst_dsp) begin
      d_state <= D_IDLE;
      payload <= 4'd0;
      req_tgl <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      d_state <= d_state_nxt;
      payload <= payload_nxt;
      req_tgl <= req_nxt;
      ovr_q   <= ovr_nxt;
    end
  end

  // DSP FSM next state; a done arriving with the ack edge starts the next transfer.
  always_comb begin
    d_state_nxt = d_state;
    payload_nxt = payload;
    req_nxt     = req_tgl;
    ovr_nxt     = ovr_q;
    case (d_state)
      D_IDLE: begin
        if (i_dsp_done) begin
          payload_nxt = {i_dsp_op, i_dsp_waddr};
          req_nxt     = ~req_tgl;
          d_state_nxt = D_PEND;
        end
      end
      D_PEND: begin
        if (ack_edge) begin
          if (i_dsp_done) begin
            payload_nxt = {i_dsp_op, i_dsp_waddr};
            req_nxt     = ~req_tgl;
          end else begin
            d_state_nxt = D_IDLE;
          end
        end else if (i_dsp_done) begin
          ovr_nxt = 1'b1;
        end
      end
      default: d_state_nxt = D_IDLE;
    endcase
  end

  // DSP-side outputs: payload is stable while pending, so it drives the CPU bus directly.
  always_comb begin
    o_cpl_data    = payload;
    o_dsp_overrun = ovr_q;
  end

endmodule

// File: tb/tb_dsp_cpl_sync.sv
`timescale 1ns/1ps
// Bench for dsp_cpl_sync: directed scenarios plus randomized back-to-back traffic,
// checked against a transaction-level model of the handshake.
module tb_dsp_cpl_sync;

  logic       clk, clk_dsp, reset;
  logic       i_start, i_dsp_done, i_cpl_ready;
  logic [1:0] i_dsp_waddr, i_dsp_op;

  logic       a_valid, a_unsol, a_busy, a_serr, a_tout, a_ovr;
  logic [3:0] a_data;
  logic       b_valid, b_unsol, b_busy, b_serr, b_tout, b_ovr;
  logic [3:0] b_data;

  localparam int TO_B = 8;

  dsp_cpl_sync dut_a (
    .clk(clk), .reset(reset), .clk_dsp(clk_dsp), .i_start(i_start),
    .i_dsp_done(i_dsp_done), .i_dsp_waddr(i_dsp_waddr), .i_dsp_op(i_dsp_op),
    .o_cpl_valid(a_valid), .i_cpl_ready(i_cpl_ready), .o_cpl_data(a_data),
    .o_cpl_unsol(a_unsol), .o_busy(a_busy), .o_start_err(a_serr),
    .o_timeout(a_tout), .o_dsp_overrun(a_ovr)
  );

  dsp_cpl_sync #(.TIMEOUT_CYCLES(TO_B)) dut_b (
    .clk(clk), .reset(reset), .clk_dsp(clk_dsp), .i_start(i_start),
    .i_dsp_done(i_dsp_done), .i_dsp_waddr(i_dsp_waddr), .i_dsp_op(i_dsp_op),
    .o_cpl_valid(b_valid), .i_cpl_ready(i_cpl_ready), .o_cpl_data(b_data),
    .o_cpl_unsol(b_unsol), .o_busy(b_busy), .o_start_err(b_serr),
    .o_timeout(b_tout), .o_dsp_overrun(b_ovr)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Transaction-level model: launch outstanding, completion presented,
  // DSP holding a payload, sticky overrun, payloads awaiting delivery.
  logic       m_busy, m_cpl, m_dsp_pend, m_ovr;
  logic [3:0] m_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    int unsigned ph;
    clk_dsp = 1'b0;
    ph = $urandom_range(100, 4700);
    #(ph * 0.001);
    forever #2.4 clk_dsp = ~clk_dsp;
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset;
    m_busy = 1'b0; m_cpl = 1'b0; m_dsp_pend = 1'b0; m_ovr = 1'b0;
    m_q.delete();
  endtask

  // One-cycle i_dsp_done; the model queues the payload or records an overrun.
  task automatic dsp_pulse(input logic [1:0] op, input logic [1:0] wa);
    @(posedge clk_dsp);
    #0.2;
    i_dsp_done = 1'b1; i_dsp_op = op; i_dsp_waddr = wa;
    @(posedge clk_dsp);
    #0.2;
    i_dsp_done = 1'b0;
    if (m_dsp_pend) m_ovr = 1'b1;
    else begin
      m_q.push_back({op, wa});
      m_dsp_pend = 1'b1;
    end
  endtask

  // One-cycle i_start, optionally with i_cpl_ready in the same cycle.
  task automatic do_start(input string tag, input logic with_ready);
    logic exp_err;
    exp_err = m_busy || (m_cpl && !with_ready);
    i_start = 1'b1; i_cpl_ready = with_ready;
    tick;
    i_start = 1'b0; i_cpl_ready = 1'b0;
    check({tag, "_err"}, 32'(a_serr), 32'(exp_err));
    if (m_cpl && with_ready) begin
      m_cpl = 1'b0; m_busy = 1'b1; m_dsp_pend = 1'b0;
      void'(m_q.pop_front());
    end else if (!m_busy && !m_cpl) begin
      m_busy = 1'b1;
    end
    check({tag, "_busy"}, 32'(a_busy), 32'(m_busy));
    check({tag, "_valid"}, 32'(a_valid), 32'(m_cpl));
  endtask

  task automatic wait_cpl(input string tag, output int lat);
    logic [3:0] exp_d;
    logic       exp_u;
    exp_u = !m_busy;
    exp_d = (m_q.size() > 0) ? m_q[0] : 4'h0;
    lat = 0;
    for (int n = 1; n <= 12; n++) begin
      tick;
      if (a_valid) begin
        lat = n;
        break;
      end
    end
    check({tag, "_seen"}, 32'(lat != 0), 32'd1);
    if (lat != 0) begin
      check({tag, "_data"}, 32'(a_data), 32'(exp_d));
      check({tag, "_unsol"}, 32'(a_unsol), 32'(exp_u));
      check({tag, "_busy"}, 32'(a_busy), 32'd0);
    end
    m_busy = 1'b0;
    m_cpl  = 1'b1;
  endtask

  task automatic consume(input string tag);
    i_cpl_ready = 1'b1;
    tick;
    i_cpl_ready = 1'b0;
    check({tag, "_valid_off"}, 32'(a_valid), 32'd0);
    check({tag, "_busy_off"}, 32'(a_busy), 32'd0);
    m_cpl = 1'b0;
    m_dsp_pend = 1'b0;
    void'(m_q.pop_front());
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(a_valid), 32'd0);
    check({tag, "_data"}, 32'(a_data), 32'd0);
    check({tag, "_unsol"}, 32'(a_unsol), 32'd0);
    check({tag, "_busy"}, 32'(a_busy), 32'd0);
    check({tag, "_serr"}, 32'(a_serr), 32'd0);
    check({tag, "_tout"}, 32'(a_tout), 32'd0);
    check({tag, "_ovr"}, 32'(a_ovr), 32'd0);
  endtask

  initial begin
    int lat, seen, nval;
    logic [3:0] pl;

    reset = 1'b1; i_start = 1'b0; i_dsp_done = 1'b0; i_cpl_ready = 1'b0;
    i_dsp_op = 2'd0; i_dsp_waddr = 2'd0;
    model_reset();
    repeat (3) tick;
    check_all_zero("reset");
    reset = 1'b0;
    repeat (5) tick;

    // Normal launch and completion: op=2, waddr=3 -> 4'hB.
    do_start("norm_start", 1'b0);
    repeat (20) tick;
    check("norm_busy_wait", 32'(a_busy), 32'd1);
    check("norm_no_tout", 32'(a_tout), 32'd0);
    dsp_pulse(2'd2, 2'd3);
    wait_cpl("norm", lat);
    check("norm_latency", 32'(lat >= 2 && lat <= 4), 32'd1);
    check("norm_data_b", 32'(a_data), 32'hB);
    consume("norm");
    repeat (4) tick;

    // Overrun: two dones two clk_dsp apart, ready held low.
    dsp_pulse(2'd1, 2'd2);
    dsp_pulse(2'd3, 2'd0);
    wait_cpl("ovr", lat);
    repeat (5) tick;
    check("ovr_flag", 32'(a_ovr), 32'(m_ovr));
    check("ovr_data_hold", 32'(a_data), 32'h6);
    check("ovr_valid_hold", 32'(a_valid), 32'd1);

    // Reset while a completion is presented and the DSP side is pending.
    reset = 1'b1;
    #1;
    check_all_zero("rst_mid");
    model_reset();
    repeat (3) tick;
    reset = 1'b0;
    seen = 0;
    for (int n = 0; n < 20; n++) begin
      tick;
      if (a_valid) seen++;
    end
    check("rst_no_valid", 32'(seen), 32'd0);
    check("rst_ovr_clr", 32'(a_ovr), 32'd0);

    // Start errors in WAIT and in CPL; start with ready in CPL relaunches.
    do_start("se_launch", 1'b0);
    do_start("se_in_wait", 1'b0);
    tick;
    check("se_pulse_one", 32'(a_serr), 32'd0);
    dsp_pulse(2'd0, 2'd1);
    wait_cpl("se_cpl", lat);
    do_start("se_in_cpl", 1'b0);
    do_start("se_ready_cpl", 1'b1);
    repeat (3) tick;
    dsp_pulse(2'd3, 2'd2);
    wait_cpl("se_second", lat);
    consume("se_second");

    // Timeout on the TIMEOUT_CYCLES=8 instance.
    reset = 1'b1;
    tick;
    reset = 1'b0;
    model_reset();
    repeat (5) tick;
    do_start("to_start", 1'b0);
    check("to_b_busy", 32'(b_busy), 32'd1);
    for (int n = 1; n <= 12; n++) begin
      tick;
      check($sformatf("to_pulse_%0d", n), 32'(b_tout), 32'(n == TO_B));
      check($sformatf("to_busy_%0d", n), 32'(b_busy), 32'(n < TO_B));
    end
    dsp_pulse(2'd2, 2'd1);
    wait_cpl("to_a", lat);
    check("to_b_valid", 32'(b_valid), 32'd1);
    check("to_b_unsol", 32'(b_unsol), 32'd1);
    check("to_b_data", 32'(b_data), 32'h9);
    consume("to");
    repeat (3) tick;

    // Back-to-back completions with random launches, payloads and spacing.
    nval = 0;
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 1) == 1) do_start("b2b_start", 1'b0);
      repeat ($urandom_range(0, 3)) @(posedge clk_dsp);
      pl = 4'($urandom);
      dsp_pulse(pl[3:2], pl[1:0]);
      wait_cpl($sformatf("b2b_%0d", i), lat);
      if (lat != 0) nval++;
      consume("b2b");
      repeat ($urandom_range(2, 4)) tick;
    end
    check("b2b_count", 32'(nval), 32'd16);
    check("b2b_no_ovr", 32'(a_ovr), 32'(m_ovr));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
